// File: rtl/polygon_pixel_writer_pkg.sv
// polygon_pixel_writer_pkg: shared co-processor colour constants and drain FSM encoding
package polygon_pixel_writer_pkg;
   localparam int COLOR_W = 9;
   localparam logic [COLOR_W-1:0] COLOR_INVISIBLE = 9'd510;
   typedef enum logic {IDLE, REQ} drain_state_t;
endpackage

// File: rtl/polygon_pixel_writer_pixel_fifo.sv
// pixel_fifo: synchronous first-word-fall-through FIFO with a look-ahead on the second entry
// Ports: clk, reset (async active-low), push/push_data, pop,
//        head (oldest entry), second (entry behind head), full, empty, multi (two or more entries)
module pixel_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [WIDTH-1:0] second,
   output logic             full,
   output logic             empty,
   output logic             multi
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wptr, rptr, count;
   // pointers carry one extra bit so full and empty stay distinct
   assign count  = wptr - rptr;
   assign full   = count == (AW+1)'(DEPTH);
   assign empty  = count == '0;
   assign multi  = count > (AW+1)'(1);
   assign head   = mem[rptr[AW-1:0]];
   assign second = mem[rptr[AW-1:0] + AW'(1)];
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push && !full) wptr <= wptr + (AW+1)'(1);
         if (pop && !empty) rptr <= rptr + (AW+1)'(1);
      end
   end
   always_ff @(posedge clk) begin
      if (push && !full) mem[wptr[AW-1:0]] <= push_data;
   end
endmodule

// File: rtl/polygon_pixel_writer.sv
// polygon_pixel_writer: tags colour-stage pixels with framebuffer addresses and drains visible ones to VRAM
// Ports: clk, reset (async active-low); in_wr/in_color/in_frame_start from the colour stage;
//        out_mem_req/out_mem_addr/out_mem_data with in_mem_ack towards the memory controller;
//        out_frame_done pulse, sticky out_overflow, out_busy.
// Optional: POLYGON_PIXEL_WRITER_STATS_EN adds out_px_count, per-frame count of acknowledged writes.
module polygon_pixel_writer
   import polygon_pixel_writer_pkg::*;
#(
   parameter int H_RES      = 640,
   parameter int V_RES      = 480,
   parameter int ADDR_W     = 19,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_wr,
   input  logic [COLOR_W-1:0] in_color,
   input  logic               in_frame_start,
   input  logic               in_mem_ack,
   output logic               out_mem_req,
   output logic [ADDR_W-1:0]  out_mem_addr,
   output logic [COLOR_W-1:0] out_mem_data,
   output logic               out_frame_done,
   output logic               out_overflow,
`ifdef POLYGON_PIXEL_WRITER_STATS_EN
   output logic [ADDR_W-1:0]  out_px_count,
`endif
   output logic               out_busy
);
   localparam int TOTAL   = H_RES * V_RES;
   localparam int ENTRY_W = ADDR_W + COLOR_W;
   logic [ADDR_W-1:0]  pix_addr, pix_next, tag, addr_next;
   logic [COLOR_W-1:0] data_next;
   logic [ENTRY_W-1:0] head, second;
   logic last, visible, push, pop, full, empty, multi, req_next;
   drain_state_t state, state_next;
   pixel_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) fifo (
      .clk(clk), .reset(reset), .push(push), .push_data({tag, in_color}), .pop(pop),
      .head(head), .second(second), .full(full), .empty(empty), .multi(multi)
   );
   // frame start wins over the increment and never counts as the end of a frame
   always_comb begin
      tag      = in_frame_start ? '0 : pix_addr;
      last     = in_wr && !in_frame_start && pix_addr == ADDR_W'(TOTAL - 1);
      pix_next = in_frame_start ? ADDR_W'(in_wr) :
                 in_wr ? (last ? '0 : pix_addr + ADDR_W'(1)) : pix_addr;
      visible  = in_wr && in_color != COLOR_INVISIBLE;
      push     = visible && !full;
   end
   // the requested entry stays at the FIFO head until acknowledged, so it keeps occupying a slot
   always_comb begin
      state_next = state;
      req_next   = out_mem_req;
      addr_next  = out_mem_addr;
      data_next  = out_mem_data;
      pop        = 1'b0;
      case (state)
         IDLE: if (!empty) begin
            state_next             = REQ;
            req_next               = 1'b1;
            {addr_next, data_next} = head;
         end
         REQ: if (in_mem_ack) begin
            pop = 1'b1;
            if (multi) {addr_next, data_next} = second;
            else begin
               state_next = IDLE;
               req_next   = 1'b0;
            end
         end
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         out_mem_req    <= 1'b0;
         out_mem_addr   <= '0;
         out_mem_data   <= '0;
         pix_addr       <= '0;
         out_frame_done <= 1'b0;
         out_overflow   <= 1'b0;
      end else begin
         state          <= state_next;
         out_mem_req    <= req_next;
         out_mem_addr   <= addr_next;
         out_mem_data   <= data_next;
         pix_addr       <= pix_next;
         out_frame_done <= last;
         out_overflow   <= out_overflow | (visible && full);
      end
   end
   assign out_busy = !empty || out_mem_req;
`ifdef POLYGON_PIXEL_WRITER_STATS_EN
   logic [ADDR_W-1:0] px_cnt;
   // an acknowledge landing on the frame_done cycle is credited to the new frame
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         px_cnt       <= '0;
         out_px_count <= '0;
      end else if (out_frame_done) begin
         out_px_count <= px_cnt;
         px_cnt       <= ADDR_W'(pop);
      end else if (pop && px_cnt != '1) begin
         px_cnt <= px_cnt + ADDR_W'(1);
      end
   end
`endif
endmodule

// File: tb/tb_polygon_pixel_writer.sv
// tb_polygon_pixel_writer: directed and random stimulus against a queue-based scoreboard model
module tb_polygon_pixel_writer;
   localparam int H = 4, V = 2, AW = 3, D = 4, TOTAL = H * V;
   logic clk = 1'b0, reset = 1'b0;
   logic in_wr = 1'b0, in_frame_start = 1'b0, in_mem_ack = 1'b0;
   logic [8:0] in_color = '0;
   logic out_mem_req, out_frame_done, out_overflow, out_busy;
   logic [AW-1:0] out_mem_addr;
   logic [8:0] out_mem_data;
   int n_chk = 0, n_pass = 0, fd_count = 0, m_addr = 0;
   bit ovf_m = 0;
   int exp_a[$], exp_c[$];
   always #5 clk = ~clk;
   polygon_pixel_writer #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .FIFO_DEPTH(D)) dut (
      .clk(clk), .reset(reset), .in_wr(in_wr), .in_color(in_color),
      .in_frame_start(in_frame_start), .in_mem_ack(in_mem_ack),
      .out_mem_req(out_mem_req), .out_mem_addr(out_mem_addr), .out_mem_data(out_mem_data),
      .out_frame_done(out_frame_done), .out_overflow(out_overflow), .out_busy(out_busy)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask
   // one clock: update the model from the stable pre-edge inputs, then check after the edge
   task automatic cyc();
      bit full_m, hs, fd_exp, vis, hold;
      int tag;
      logic [AW-1:0] pa;
      logic [8:0] pd;
      hs = out_mem_req && in_mem_ack;
      full_m = exp_a.size() == D;
      if (hs) begin
         if (exp_a.size() == 0) chk("write_model_nonempty", exp_a.size(), 1);
         else begin
            chk("wr_addr", out_mem_addr, exp_a[0]);
            chk("wr_data", out_mem_data, exp_c[0]);
            void'(exp_a.pop_front());
            void'(exp_c.pop_front());
         end
      end
      vis = in_wr && in_color != 9'd510;
      tag = in_frame_start ? 0 : m_addr;
      if (vis) begin
         if (full_m) ovf_m = 1;
         else begin
            exp_a.push_back(tag);
            exp_c.push_back(int'(in_color));
         end
      end
      fd_exp = in_wr && !in_frame_start && m_addr == TOTAL - 1;
      m_addr = in_frame_start ? (in_wr ? 1 : 0) : in_wr ? (m_addr + 1) % TOTAL : m_addr;
      hold = out_mem_req && !in_mem_ack;
      pa = out_mem_addr;
      pd = out_mem_data;
      @(posedge clk);
      @(negedge clk);
      fd_count += int'(out_frame_done);
      chk("frame_done", out_frame_done, fd_exp);
      chk("overflow", out_overflow, ovf_m);
      chk("busy", out_busy, exp_a.size() != 0);
      if (hold) begin
         chk("hold_req", out_mem_req, 1);
         chk("hold_addr", out_mem_addr, pa);
         chk("hold_data", out_mem_data, pd);
      end
      if (out_mem_req) begin
         chk("req_model_nonempty", exp_a.size() != 0, 1);
         if (exp_a.size() != 0) begin
            chk("req_head_addr", out_mem_addr, exp_a[0]);
            chk("req_head_data", out_mem_data, exp_c[0]);
         end
      end
   endtask
   task automatic drive(input bit wr, input int col, input bit fs);
      in_wr = wr;
      in_color = col[8:0];
      in_frame_start = fs;
      cyc();
      in_wr = 0;
      in_frame_start = 0;
   endtask
   task automatic drain();
      in_mem_ack = 1;
      for (int i = 0; i < 60 && (exp_a.size() != 0 || out_mem_req); i++) cyc();
      chk("drained", exp_a.size(), 0);
      chk("drained_req", out_mem_req, 0);
   endtask
   initial begin
      #2;
      chk("rst_req", out_mem_req, 0);
      chk("rst_addr", out_mem_addr, 0);
      chk("rst_data", out_mem_data, 0);
      chk("rst_frame_done", out_frame_done, 0);
      chk("rst_overflow", out_overflow, 0);
      chk("rst_busy", out_busy, 0);
      @(negedge clk);
      reset = 1;
      // single pixel: push, load, then request
      in_mem_ack = 1;
      drive(1, 100, 0);
      chk("lat_push_req", out_mem_req, 0);
      cyc();
      chk("lat_req", out_mem_req, 1);
      chk("lat_addr", out_mem_addr, 0);
      chk("lat_data", out_mem_data, 100);
      cyc();
      chk("req_drop", out_mem_req, 0);
      // invisible pixel consumes an address but no write
      drive(0, 0, 1);
      drive(1, 510, 0);
      drive(1, 7, 0);
      drive(1, 8, 0);
      drain();
      // back-pressure: four entries fit, the fifth is dropped
      in_mem_ack = 0;
      for (int i = 0; i < 5; i++) drive(1, 20 + i, 0);
      chk("ovf_set", out_overflow, 1);
      drain();
      chk("ovf_sticky", out_overflow, 1);
      // full frame of eight pixels, then the wrap
      drive(0, 0, 1);
      fd_count = 0;
      for (int i = 0; i < 8; i++) drive(1, 40 + i, 0);
      chk("frame_done_after_8th", out_frame_done, 1);
      drive(1, 60, 0);
      drain();
      chk("frame_done_once", fd_count, 1);
      // mid-frame restart with a coincident pixel
      for (int i = 0; i < 5; i++) drive(1, 70 + i, 0);
      drive(1, 3, 1);
      drive(1, 9, 0);
      drain();
      // random traffic
      for (int i = 0; i < 400; i++) begin
         in_mem_ack = $urandom_range(0, 3) != 0;
         drive($urandom_range(0, 1) == 1,
               $urandom_range(0, 7) == 0 ? 510 : int'($urandom_range(0, 511)),
               $urandom_range(0, 40) == 0);
      end
      drain();
      // asynchronous reset while a request is outstanding
      in_mem_ack = 0;
      drive(1, 55, 0);
      cyc();
      cyc();
      chk("pre_reset_req", out_mem_req, 1);
      #2 reset = 0;
      #1;
      chk("async_req_drop", out_mem_req, 0);
      chk("async_busy", out_busy, 0);
      exp_a.delete();
      exp_c.delete();
      ovf_m = 0;
      m_addr = 0;
      @(negedge clk);
      reset = 1;
      cyc();
      chk("post_reset_busy", out_busy, 0);
      in_mem_ack = 1;
      drive(1, 77, 0);
      drain();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/polygon_pixel_writer.md
Name: polygon_pixel_writer

Overview:
- Consumer end of the color-comparator output stream: accepts one resolved pixel color per `in_wr` strobe and assigns it a linear framebuffer address.
- Buffers visible pixels in a small FIFO and drains them to the VRAM write port through a req/ack handshake.
- Sits between the co-processor color stage and the framebuffer memory controller.

Parameters:
- H_RES, 640, pixels per line
- V_RES, 480, lines per frame
- ADDR_W, 19, framebuffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES
- FIFO_DEPTH, 4, pixel FIFO entries; power of two, minimum 2

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low
- in_wr  input  1  pixel-valid strobe from color stage, one pixel per high cycle
- in_color  input  9  resolved pixel color; 9'd510 = invisible
- in_frame_start  input  1  single-cycle pulse; restarts pixel address at 0
- in_mem_ack  input  1  memory accepted current write
- out_mem_req  output  1  write request
- out_mem_addr  output  ADDR_W  write address
- out_mem_data  output  9  write color
- out_frame_done  output  1  single-cycle pulse after last pixel of a frame is accepted
- out_overflow  output  1  sticky; a visible pixel was dropped
- out_busy  output  1  FIFO non-empty or request outstanding

Behaviour:
- Reset (async, active-low) forces:
  - all outputs to 0
  - pixel counter to 0
  - FIFO empty
  - FSM to IDLE
- Pixel counter `pix_addr` (ADDR_W bits):
  - Each cycle with `in_wr`=1, the pixel is tagged with the current `pix_addr`, then `pix_addr` increments.
  - At H_RES*V_RES-1, the counter wraps to 0 and `out_frame_done` pulses on the next cycle.
- `in_frame_start` takes priority over the increment:
  - Without `in_wr`: `pix_addr` becomes 0.
  - With `in_wr`: the pixel is tagged 0 and `pix_addr` becomes 1.
  - Mid-frame `in_frame_start` discards no FIFO contents and does not pulse `out_frame_done`.
- Invisible pixels (`in_color`==510) advance `pix_addr` but are never pushed.
- Push: visible `in_wr` with FIFO not full stores {addr,color}.
  - If the FIFO is full, the pixel is dropped and `out_overflow` sets (cleared only by reset).
  - A pop in the same cycle does not free space for that push: full is evaluated before the pop.
- Drain FSM:
  - IDLE: if FIFO non-empty, load head into `out_mem_addr`/`out_mem_data`, assert `out_mem_req`, go to REQ.
  - REQ: hold req, addr and data stable until `in_mem_ack`=1. On ack, pop the head.
    - If the FIFO still holds an entry after the pop, load it and stay in REQ, keeping req high.
    - Otherwise drop req and return to IDLE.
  - An ack while in IDLE is ignored.
- Latency: a visible pixel with an empty FIFO and the FSM in IDLE gives `out_mem_req` 2 cycles after its `in_wr` (push cycle, then load cycle).
- Throughput: with `in_mem_ack` tied high, one write per cycle.
- `out_busy` = FIFO non-empty OR `out_mem_req`.
- Reset mid-transfer: req drops immediately (async); pending pixels are lost.

Optional Feature:
- Macro: POLYGON_PIXEL_WRITER_STATS_EN
- Defined:
  - Adds output `out_px_count` [ADDR_W-1:0] counting pixels acknowledged by memory in the current frame.
  - Snapshot is registered to `out_px_count` on the `out_frame_done` pulse; the internal counter then clears.
  - Saturates at all-ones.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared co-processor package:
  - constant COLOR_INVISIBLE = 9'd510
  - COLOR_W = 9
  - FSM state encoding (IDLE, REQ)
- One natural sub-module: `pixel_fifo` (synchronous, parameterised width/depth, full/empty flags, first-word-fall-through head).

Test Plan:
- Reset → all outputs 0. Then `in_wr` with color 9'd100 and ack held high → req asserted 2 cycles later, addr 0, data 100; req drops the cycle after ack.
- Three consecutive pixels (colors 510, 7, 8) with ack high → writes only addr 1 (color 7) and addr 2 (color 8); no write at addr 0.
- Ack held low, 5 visible pixels with FIFO_DEPTH=4 → FIFO accepts 4. Of those, 1 moves to the request register and drains; the last pixel is dropped, `out_overflow`=1 and stays 1 after draining.
- H_RES=4, V_RES=2, 8 `in_wr` → `out_frame_done` pulses once, one cycle after the 8th; the next pixel gets addr 0.
- `in_frame_start` coincident with `in_wr` color 3 after 5 pixels → pixel written at addr 0; the next pixel gets addr 1.
- Async reset asserted while `out_mem_req`=1 → req drops without waiting for clk; after release, `out_busy`=0.
